scard_cmd_sequencer: RTL and testbench
======================================

Name: scard_cmd_sequencer

Overview:
- Controller that sequences one smartcard transaction on serial_scard_hls_iface.
- Triggers the command with a do_cmd pulse, waits for the TX FIFO to drain, then pops a host-specified number of response bytes from the RX FIFO.
- Streams the response bytes to the host logic, with an inactivity timeout and an inter-command guard time.
- Sits between the host register/USB command logic and the smartcard interface.

Parameters:
- TIMEOUT_W, 24, width of the inactivity timeout counter.
- TIMEOUT_CYCLES, 1000000, clk_i cycles with no progress before timeout (must be ≥2 and < 2^TIMEOUT_W).
- GUARD_CYCLES, 16, idle cycles enforced after each transaction before the next start is accepted (1..255).

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start-transaction strobe; sampled only in IDLE.
- abort_i  in  1  abandon the current transaction.
- rsp_len_i  in  8  expected response bytes, latched at start; 0 means no RX phase.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at transaction end (normal or timeout).
- timeout_o  out  1  sticky timeout flag; cleared by the next accepted start.
- rx_count_o  out  8  bytes received in the current/last transaction.
- rsp_data_o  out  8  last captured response byte.
- rsp_valid_o  out  1  one-cycle strobe, rsp_data_o is new.
- do_cmd_o  out  1  command trigger to the interface.
- scardfifo_rxe_i  in  1  RX FIFO empty.
- scardfifo_txe_i  in  1  TX FIFO empty.
- scardfifo_rd_o  out  1  RX FIFO pop.
- scardfifo_din_i  in  8  RX FIFO data; valid the cycle after scardfifo_rd_o.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0. Reset is asynchronous; asserting it mid-transaction aborts immediately. No done_o is issued for the aborted transaction.
- States: IDLE, CMD, TXWAIT, RXWAIT, RDREQ, RDCAP, GUARD.
- IDLE:
  - start_i=1 latches rsp_len_i, clears rx_count_o and timeout_o, and goes to CMD.
  - start_i in any other state is ignored.
- CMD: do_cmd_o=1 for exactly this one cycle, then TXWAIT. The timeout counter is cleared.
- TXWAIT:
  - Sets a seen-busy flag when scardfifo_txe_i=0.
  - When seen-busy=1 and scardfifo_txe_i=1: go to GUARD with done_o if the latched length is 0, otherwise go to RXWAIT with the timeout counter cleared.
- RXWAIT: scardfifo_rxe_i=0 goes to RDREQ.
- RDREQ:
  - scardfifo_rd_o=1 for this cycle only, then RDCAP.
  - Never more than one pop is outstanding.
- RDCAP:
  - rsp_data_o<=scardfifo_din_i, rsp_valid_o=1 for one cycle, rx_count_o increments, timeout counter clears.
  - If the new count equals the latched length: go to GUARD with done_o. Otherwise go to RXWAIT.
  - Steady-state pop rate is therefore at most one byte per 3 cycles.
- Timeout:
  - The counter increments in TXWAIT and RXWAIT.
  - On reaching TIMEOUT_CYCLES-1: timeout_o=1, done_o pulse, go to GUARD.
  - Bytes captured so far remain in rx_count_o.
  - Progress (a TXWAIT exit condition, or rxe=0 in RXWAIT) in the same cycle as the timeout terminal count: progress wins, no timeout.
- GUARD: counts GUARD_CYCLES cycles, then IDLE. busy_o stays high throughout.
- abort_i:
  - In any non-IDLE state except GUARD, abort goes to GUARD next cycle, with no done_o and timeout_o unchanged.
  - A byte popped in RDREQ is discarded; no rsp_valid_o.
  - abort_i in IDLE or GUARD has no effect.
  - abort_i has priority over all other transitions, including completion in RDCAP.
- Excess RX bytes beyond the latched length are left in the FIFO; the sequencer never pops them.
- rx_count_o never wraps, because the maximum is 255 = the maximum length.

Test Plan:
- Normal: rsp_len_i=4; TX empty goes 1→0→1 after 20 cycles; 4 bytes 0xA1..0xA4 → exactly one do_cmd_o pulse, four rd pulses, rsp_valid_o ×4 with data A1..A4, done_o once, rx_count_o=4, timeout_o=0, busy_o low GUARD_CYCLES cycles after done_o.
- Zero length: rsp_len_i=0 → done_o after txe returns to 1; scardfifo_rd_o never asserted; rx_count_o=0.
- Timeout: TIMEOUT_CYCLES=50; rsp_len_i=3; only 1 byte supplied → done_o and timeout_o=1 exactly 50 cycles after that byte's capture, rx_count_o=1; the next start clears timeout_o.
- Abort in RDREQ: abort_i pulsed in RDREQ → no rsp_valid_o, no done_o, GUARD then IDLE; a new start is accepted only after the guard time.
- Start ignored while busy: start_i pulses during RXWAIT and GUARD → no second do_cmd_o; rsp_len_i changes are not latched.
- Reset mid-RX: reset_i asserted in RXWAIT → all outputs 0 asynchronously; after release, a fresh transaction completes normally.

Source files
------------

// File: rtl/scard_cmd_sequencer.sv
// Sequences one smartcard transaction: pulses do_cmd, waits for the TX FIFO
// to drain, then pops the latched number of response bytes from the RX FIFO.
// Handles an inactivity timeout, abort, and an inter-transaction guard time.
// Ports: start_i/abort_i/rsp_len_i from the host; busy/done/timeout/rx_count
// and the rsp_data/rsp_valid stream back to the host; do_cmd_o,
// scardfifo_rd_o, scardfifo_rxe_i/txe_i/din_i toward the smartcard interface.
module scard_cmd_sequencer #(
  parameter int unsigned TIMEOUT_W      = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned GUARD_CYCLES   = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] rsp_len_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_o,
  output logic [7:0] rx_count_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_valid_o,
  output logic       do_cmd_o,
  input  logic       scardfifo_rxe_i,
  input  logic       scardfifo_txe_i,
  output logic       scardfifo_rd_o,
  input  logic [7:0] scardfifo_din_i
);

  localparam logic [TIMEOUT_W-1:0] TMO_LAST   = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]           GUARD_LAST = 8'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_TXWAIT, S_RXWAIT, S_RDREQ, S_RDCAP, S_GUARD
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           rx_count_q, rx_count_d;
  logic [7:0]           rsp_data_q, rsp_data_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 seen_busy_q, seen_busy_d;
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]           guard_cnt_q, guard_cnt_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      rx_count_q  <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      seen_busy_q <= 1'b0;
      tmo_cnt_q   <= '0;
      guard_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rx_count_q  <= rx_count_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      seen_busy_q <= seen_busy_d;
      tmo_cnt_q   <= tmo_cnt_d;
      guard_cnt_q <= guard_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rx_count_d  = rx_count_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    done_d      = 1'b0;
    timeout_d   = timeout_q;
    seen_busy_d = seen_busy_q;
    tmo_cnt_d   = tmo_cnt_q;
    guard_cnt_d = '0;

    // Abort outranks every other transition, including RDCAP completion.
    if (abort_i && state_q != S_IDLE && state_q != S_GUARD) begin
      state_d = S_GUARD;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            len_d      = rsp_len_i;
            rx_count_d = '0;
            timeout_d  = 1'b0;
            state_d    = S_CMD;
          end
        end
        S_CMD: begin
          tmo_cnt_d   = '0;
          seen_busy_d = 1'b0;
          state_d     = S_TXWAIT;
        end
        S_TXWAIT: begin
          // Progress is checked before the terminal count so it wins a tie.
          if (seen_busy_q && scardfifo_txe_i) begin
            tmo_cnt_d = '0;
            if (len_q == 8'd0) begin
              done_d  = 1'b1;
              state_d = S_GUARD;
            end else begin
              state_d = S_RXWAIT;
            end
          end else if (tmo_cnt_q == TMO_LAST) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            state_d   = S_GUARD;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (!scardfifo_txe_i) seen_busy_d = 1'b1;
          end
        end
        S_RXWAIT: begin
          if (!scardfifo_rxe_i) begin
            state_d = S_RDREQ;
          end else if (tmo_cnt_q == TMO_LAST) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            state_d   = S_GUARD;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
        S_RDREQ: state_d = S_RDCAP;
        S_RDCAP: begin
          rsp_data_d  = scardfifo_din_i;
          rsp_valid_d = 1'b1;
          rx_count_d  = rx_count_q + 8'd1;
          tmo_cnt_d   = '0;
          if (rx_count_d == len_q) begin
            done_d  = 1'b1;
            state_d = S_GUARD;
          end else begin
            state_d = S_RXWAIT;
          end
        end
        S_GUARD: begin
          if (guard_cnt_q == GUARD_LAST) state_d = S_IDLE;
          else guard_cnt_d = guard_cnt_q + 8'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign do_cmd_o       = (state_q == S_CMD);
  assign scardfifo_rd_o = (state_q == S_RDREQ);
  assign done_o         = done_q;
  assign timeout_o      = timeout_q;
  assign rx_count_o     = rx_count_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_valid_o    = rsp_valid_q;

endmodule

// File: tb/tb_scard_cmd_sequencer.sv
module tb_scard_cmd_sequencer;

  localparam int TMO = 50;
  localparam int GRD = 16;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic       abort_i;
  logic [7:0] rsp_len_i;
  logic       busy_o, done_o, timeout_o, rsp_valid_o, do_cmd_o, scardfifo_rd_o;
  logic [7:0] rx_count_o, rsp_data_o;
  logic       scardfifo_rxe_i, scardfifo_txe_i;
  logic [7:0] scardfifo_din_i;

  scard_cmd_sequencer #(
    .TIMEOUT_W     (24),
    .TIMEOUT_CYCLES(TMO),
    .GUARD_CYCLES  (GRD)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .rsp_len_i      (rsp_len_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .timeout_o      (timeout_o),
    .rx_count_o     (rx_count_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_valid_o    (rsp_valid_o),
    .do_cmd_o       (do_cmd_o),
    .scardfifo_rxe_i(scardfifo_rxe_i),
    .scardfifo_txe_i(scardfifo_txe_i),
    .scardfifo_rd_o (scardfifo_rd_o),
    .scardfifo_din_i(scardfifo_din_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_cmd, n_rd, n_valid, n_done;
  int done_cyc, last_valid_cyc;
  logic [7:0] data_seen[$];
  logic [7:0] rxq[$];
  logic [7:0] pat[$];

  // One clock: RX FIFO model (data appears the cycle after a pop) plus monitor.
  task automatic tick();
    logic prev_rd;
    prev_rd = scardfifo_rd_o;
    @(posedge clk_i);
    #1;
    cyc++;
    if (prev_rd) begin
      checks++;
      if (rxq.size() == 0) begin
        failures++;
        $display("FAIL pop_empty got=empty exp=nonempty at cyc %0d", cyc);
      end else begin
        scardfifo_din_i = rxq.pop_front();
      end
    end
    scardfifo_rxe_i = (rxq.size() == 0);
    if (do_cmd_o) n_cmd++;
    if (scardfifo_rd_o) n_rd++;
    if (rsp_valid_o) begin
      n_valid++;
      data_seen.push_back(rsp_data_o);
      last_valid_cyc = cyc;
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
    end
  endtask

  task automatic clr_mon();
    n_cmd = 0; n_rd = 0; n_valid = 0; n_done = 0;
    done_cyc = -1; last_valid_cyc = -1;
    data_seen.delete();
  endtask

  task automatic flush_rx();
    rxq.delete();
    scardfifo_rxe_i = 1'b1;
  endtask

  // Runs one transaction with response bytes from pat[], supplied once TX drains.
  task automatic run_txn(input logic [7:0] len, input int tx_busy, input bit poke, input string tag);
    int exp_n, rise_cyc, k, budget, idle_cyc;
    bit exp_tmo;
    exp_n   = (pat.size() < int'(len)) ? pat.size() : int'(len);
    exp_tmo = (pat.size() < int'(len));
    budget  = TMO + 4 * int'(len) + 30;
    clr_mon();
    start_i = 1'b1; rsp_len_i = len;
    tick();
    start_i = 1'b0; rsp_len_i = 8'($urandom);
    checks++;
    if ({busy_o, timeout_o, rx_count_o, do_cmd_o} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL %s.start_accept got={busy,tmo,cnt,cmd}=%h exp=%h", tag,
               {busy_o, timeout_o, rx_count_o, do_cmd_o}, {1'b1, 1'b0, 8'h00, 1'b1});
    end
    scardfifo_txe_i = 1'b0;
    repeat (tx_busy) tick();
    scardfifo_txe_i = 1'b1;
    rise_cyc = cyc;
    if (poke) begin
      tick();
      start_i = 1'b1; rsp_len_i = len + 8'd3;
      tick();
      start_i = 1'b0;
    end
    foreach (pat[i]) rxq.push_back(pat[i]);
    scardfifo_rxe_i = (rxq.size() == 0);
    k = 0;
    while (n_done == 0 && k < budget) begin tick(); k++; end
    checks++;
    if (n_done == 0) begin
      failures++;
      $display("FAIL %s.done_seen got=none exp=pulse within %0d cycles", tag, budget);
    end else begin
      checks++;
      if (len == 8'd0) begin
        if (done_cyc != rise_cyc + 1) begin
          failures++;
          $display("FAIL %s.done_latency got=%0d exp=%0d", tag, done_cyc - rise_cyc, 1);
        end
      end else if (exp_tmo && exp_n == 0) begin
        if (done_cyc - rise_cyc != TMO + 1) begin
          failures++;
          $display("FAIL %s.tmo_latency got=%0d exp=%0d", tag, done_cyc - rise_cyc, TMO + 1);
        end
      end else if (exp_tmo) begin
        if (done_cyc - last_valid_cyc != TMO) begin
          failures++;
          $display("FAIL %s.tmo_latency got=%0d exp=%0d", tag, done_cyc - last_valid_cyc, TMO);
        end
      end else begin
        if (done_cyc != last_valid_cyc) begin
          failures++;
          $display("FAIL %s.done_with_last got=%0d exp=%0d", tag, done_cyc, last_valid_cyc);
        end
      end
    end
    k = 0;
    while (busy_o && k < GRD + 10) begin
      start_i = (poke && k == 3);
      tick();
      k++;
    end
    start_i = 1'b0;
    idle_cyc = cyc;
    checks++;
    if (busy_o !== 1'b0 || idle_cyc != done_cyc + GRD) begin
      failures++;
      $display("FAIL %s.guard_len got=%0d exp=%0d busy=%b", tag, idle_cyc - done_cyc, GRD, busy_o);
    end
    checks++;
    if (n_cmd != 1 || n_done != 1 || n_rd != exp_n || n_valid != exp_n) begin
      failures++;
      $display("FAIL %s.pulse_counts got cmd=%0d done=%0d rd=%0d valid=%0d exp 1 1 %0d %0d",
               tag, n_cmd, n_done, n_rd, n_valid, exp_n, exp_n);
    end
    checks++;
    if (rx_count_o !== 8'(exp_n) || timeout_o !== exp_tmo) begin
      failures++;
      $display("FAIL %s.status got cnt=%0d tmo=%b exp cnt=%0d tmo=%b", tag,
               rx_count_o, timeout_o, exp_n, exp_tmo);
    end
    for (int i = 0; i < exp_n && i < data_seen.size(); i++) begin
      checks++;
      if (data_seen[i] !== pat[i]) begin
        failures++;
        $display("FAIL %s.data[%0d] got=%h exp=%h", tag, i, data_seen[i], pat[i]);
      end
    end
    checks++;
    if (rxq.size() != pat.size() - exp_n) begin
      failures++;
      $display("FAIL %s.leftover got=%0d exp=%0d", tag, rxq.size(), pat.size() - exp_n);
    end
    flush_rx();
  endtask

  task automatic test_reset();
    reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; rsp_len_i = '0;
    scardfifo_rxe_i = 1'b1; scardfifo_txe_i = 1'b1; scardfifo_din_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({busy_o, done_o, timeout_o, rsp_valid_o, do_cmd_o, scardfifo_rd_o} !== 6'b0 ||
        rx_count_o !== 8'h00 || rsp_data_o !== 8'h00) begin
      failures++;
      $display("FAIL reset.outputs got ctl=%b cnt=%h data=%h exp all zero",
               {busy_o, done_o, timeout_o, rsp_valid_o, do_cmd_o, scardfifo_rd_o}, rx_count_o, rsp_data_o);
    end
    reset_i = 1'b0;
    clr_mon();
    repeat (3) tick();
    checks++;
    if (busy_o !== 1'b0 || n_cmd != 0) begin
      failures++;
      $display("FAIL reset.idle_hold got busy=%b cmd=%0d exp busy=0 cmd=0", busy_o, n_cmd);
    end
  endtask

  task automatic test_normal();
    pat = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    run_txn(8'd4, 20, 1'b0, "normal");
  endtask

  task automatic test_zero_len();
    pat = '{8'h99, 8'h98};
    run_txn(8'd0, 7, 1'b0, "zero_len");
  endtask

  task automatic test_timeout();
    pat = '{8'h77};
    run_txn(8'd3, 10, 1'b0, "timeout");
    pat = '{8'h42};
    run_txn(8'd1, 5, 1'b0, "after_timeout");
  endtask

  task automatic test_abort_rdreq();
    int k, abort_cyc;
    clr_mon();
    pat = '{8'h11, 8'h22, 8'h33};
    start_i = 1'b1; rsp_len_i = 8'd3;
    tick();
    start_i = 1'b0;
    scardfifo_txe_i = 1'b0;
    repeat (4) tick();
    scardfifo_txe_i = 1'b1;
    foreach (pat[i]) rxq.push_back(pat[i]);
    scardfifo_rxe_i = 1'b0;
    k = 0;
    while (n_rd < 2 && k < 40) begin tick(); k++; end
    checks++;
    if (n_rd < 2) begin
      failures++;
      $display("FAIL abort.reach_rdreq got rd=%0d exp=2", n_rd);
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    abort_cyc = cyc;
    k = 0;
    while (busy_o && k < GRD + 10) begin
      start_i = (k == 5);
      tick();
      k++;
    end
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || cyc != abort_cyc + GRD) begin
      failures++;
      $display("FAIL abort.guard_len got=%0d exp=%0d", cyc - abort_cyc, GRD);
    end
    checks++;
    if (n_valid != 1 || n_done != 0 || n_cmd != 1 || rx_count_o !== 8'd1 || timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL abort.status got valid=%0d done=%0d cmd=%0d cnt=%0d tmo=%b exp 1 0 1 1 0",
               n_valid, n_done, n_cmd, rx_count_o, timeout_o);
    end
    checks++;
    if (data_seen.size() < 1 || data_seen[0] !== 8'h11) begin
      failures++;
      $display("FAIL abort.first_byte got=%h exp=11", (data_seen.size() > 0) ? data_seen[0] : 8'hxx);
    end
    checks++;
    if (rxq.size() != 1) begin
      failures++;
      $display("FAIL abort.leftover got=%0d exp=1", rxq.size());
    end
    flush_rx();
    clr_mon();
    start_i = 1'b1; rsp_len_i = 8'd0;
    tick();
    start_i = 1'b0;
    checks++;
    if (do_cmd_o !== 1'b1) begin
      failures++;
      $display("FAIL abort.restart got do_cmd=%b exp=1", do_cmd_o);
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    k = 0;
    while (busy_o && k < GRD + 10) begin tick(); k++; end
    checks++;
    if (busy_o !== 1'b0 || n_done != 0 || n_cmd != 1) begin
      failures++;
      $display("FAIL abort.cmd_abort got busy=%b done=%0d cmd=%0d exp 0 0 1", busy_o, n_done, n_cmd);
    end
  endtask

  task automatic test_start_ignored();
    pat = '{8'h3C, 8'hC3};
    run_txn(8'd2, 6, 1'b1, "start_ignored");
  endtask

  task automatic test_reset_mid_rx();
    int k;
    clr_mon();
    pat = '{8'h5A};
    start_i = 1'b1; rsp_len_i = 8'd3;
    tick();
    start_i = 1'b0;
    scardfifo_txe_i = 1'b0;
    repeat (3) tick();
    scardfifo_txe_i = 1'b1;
    rxq.push_back(8'h5A);
    scardfifo_rxe_i = 1'b0;
    k = 0;
    while (n_valid == 0 && k < 40) begin tick(); k++; end
    repeat (3) tick();
    checks++;
    if (busy_o !== 1'b1 || rx_count_o !== 8'd1) begin
      failures++;
      $display("FAIL rst_mid.pre got busy=%b cnt=%0d exp busy=1 cnt=1", busy_o, rx_count_o);
    end
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if ({busy_o, done_o, timeout_o, rsp_valid_o, do_cmd_o, scardfifo_rd_o} !== 6'b0 ||
        rx_count_o !== 8'h00 || rsp_data_o !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid.async got ctl=%b cnt=%h data=%h exp all zero",
               {busy_o, done_o, timeout_o, rsp_valid_o, do_cmd_o, scardfifo_rd_o}, rx_count_o, rsp_data_o);
    end
    tick();
    tick();
    reset_i = 1'b0;
    flush_rx();
    pat.delete();
    for (int i = 0; i < 3; i++) pat.push_back(8'($urandom));
    run_txn(8'd3, 6, 1'b0, "post_reset");
  endtask

  task automatic test_random();
    int len, n_sup;
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(0, 6);
      if (len > 0 && $urandom_range(0, 3) == 0) n_sup = $urandom_range(0, len - 1);
      else n_sup = len + $urandom_range(0, 2);
      pat.delete();
      for (int i = 0; i < n_sup; i++) pat.push_back(8'($urandom));
      run_txn(8'(len), $urandom_range(2, 20), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero_len();
    test_timeout();
    test_abort_rdreq();
    test_start_ignored();
    test_reset_mid_rx();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
